// File: rtl/prog_chain_loader.sv
// prog_chain_loader: serialises host bitstream words LSB-first onto the
// fabric configuration shift chain (prog_in / prog_en), prog_clk domain.
// Optional macro PROG_CHAIN_CRC_EN adds tx_crc / rb_crc CRC-32 outputs
// over the transmitted bits and the chain's readback bits.
module prog_chain_loader #(
    parameter int CHAIN_LEN = 4480,
    parameter int WORD_W    = 32
) (
    input  logic                           prog_clk,
    input  logic                           prog_rst_n,
    input  logic                           start,
    input  logic [WORD_W-1:0]              word_in,
    input  logic                           word_valid,
    output logic                           word_ready,
    output logic                           cfg_prog_in,
    output logic                           cfg_prog_en,
    input  logic                           cfg_prog_out,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
`ifdef PROG_CHAIN_CRC_EN
    ,
    output logic [31:0]                    tx_crc,
    output logic [31:0]                    rb_crc
`endif
);

    localparam int CW     = $clog2(CHAIN_LEN + 1);
    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WLW    = $clog2(NWORDS + 1);
    localparam int SCW    = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] hold_q, hold_n, shift_q, shift_n;
    logic              hold_full_q, hold_full_n;
    logic [SCW-1:0]    shift_cnt_q, shift_cnt_n;
    logic [WLW-1:0]    words_left_q, words_left_n;
    logic [CW-1:0]     bit_count_n;
    logic              prog_en_n, prog_in_n, ready_n, busy_n, done_n;
    logic              xfer;

    // Next-state: word intake into the holding register, bit emission from
    // the shift register (refilled from the holding register as it empties).
    // Bits beyond CHAIN_LEN in the final word are simply never emitted.
    always_comb begin
        state_n      = state;
        hold_n       = hold_q;
        hold_full_n  = hold_full_q;
        shift_n      = shift_q;
        shift_cnt_n  = shift_cnt_q;
        words_left_n = words_left_q;
        bit_count_n  = bit_count;
        prog_en_n    = 1'b0;
        prog_in_n    = cfg_prog_in;
        xfer         = word_valid && word_ready;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n      = LOAD;
                    bit_count_n  = '0;
                    words_left_n = WLW'(NWORDS);
                    hold_n       = '0;
                    hold_full_n  = 1'b0;
                    shift_n      = '0;
                    shift_cnt_n  = '0;
                end
            end
            LOAD: begin
                // word_ready is only high with an empty holding register,
                // so intake and consumption never collide in one cycle
                if (xfer) begin
                    hold_n       = word_in;
                    hold_full_n  = 1'b1;
                    words_left_n = words_left_q - 1'b1;
                end
                if (bit_count == CW'(CHAIN_LEN)) begin
                    state_n = DONE;
                end else if (shift_cnt_q != '0) begin
                    prog_en_n   = 1'b1;
                    prog_in_n   = shift_q[0];
                    bit_count_n = bit_count + 1'b1;
                    if (shift_cnt_q == SCW'(1) && hold_full_q) begin
                        shift_n     = hold_q;
                        shift_cnt_n = SCW'(WORD_W);
                        hold_full_n = 1'b0;
                    end else begin
                        shift_n     = shift_q >> 1;
                        shift_cnt_n = shift_cnt_q - 1'b1;
                    end
                end else if (hold_full_q) begin
                    prog_en_n   = 1'b1;
                    prog_in_n   = hold_q[0];
                    bit_count_n = bit_count + 1'b1;
                    shift_n     = hold_q >> 1;
                    shift_cnt_n = SCW'(WORD_W - 1);
                    hold_full_n = 1'b0;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
        ready_n = (state_n == LOAD) && !hold_full_n && (words_left_n != '0);
    end

    // State and registered outputs; reset aborts any load immediately
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            state        <= IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            shift_cnt_q  <= '0;
            words_left_q <= '0;
            bit_count    <= '0;
            cfg_prog_en  <= 1'b0;
            cfg_prog_in  <= 1'b0;
            word_ready   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            hold_q       <= hold_n;
            hold_full_q  <= hold_full_n;
            shift_q      <= shift_n;
            shift_cnt_q  <= shift_cnt_n;
            words_left_q <= words_left_n;
            bit_count    <= bit_count_n;
            cfg_prog_en  <= prog_en_n;
            cfg_prog_in  <= prog_in_n;
            word_ready   <= ready_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

`ifdef PROG_CHAIN_CRC_EN
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[31] ^ b;
        return {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    endfunction

    // CRCs advance on each shift edge (cfg_prog_en high), restart on start accept
    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            tx_crc <= 32'hFFFFFFFF;
            rb_crc <= 32'hFFFFFFFF;
        end else if (state == IDLE && start) begin
            tx_crc <= 32'hFFFFFFFF;
            rb_crc <= 32'hFFFFFFFF;
        end else if (cfg_prog_en) begin
            tx_crc <= crc_step(tx_crc, cfg_prog_in);
            rb_crc <= crc_step(rb_crc, cfg_prog_out);
        end
    end
`else
    logic unused_prog_out;
    assign unused_prog_out = cfg_prog_out;
`endif

endmodule
